// File: rtl/debug_unlock_ctrl.sv
// debug_unlock_ctrl
//
// Control stage upstream of the locked data register. It raises Lock once boot provisioning
// completes, then grants time-limited debug sessions. Each request goes through a key check
// with a fixed delay. After MAX_FAIL consecutive wrong keys the block enters a permanent
// lockout, which only reset clears.
//
// Ports:
//   Clk        - clock, all logic on rising edge
//   resetn     - synchronous active-low reset
//   boot_done  - provisioning complete (level or pulse), honoured only in IDLE
//   dbg_req    - single-cycle debug session request, honoured only in LOCKED
//   dbg_key    - 16-bit key, captured with an accepted dbg_req
//   dbg_exit   - ends an active debug session
//   Lock       - lock command to the register
//   trusted    - trusted-write qualifier (DEBUG only)
//   debug_mode - debug session indicator (DEBUG only)
//   dbg_ack    - one-cycle pulse, key accepted
//   dbg_nack   - one-cycle pulse, key rejected
//   lockout    - permanent lockout indicator
//   fail_count - consecutive wrong keys, saturating at MAX_FAIL
//
// Every output is a register fed from the current state or a pending-pulse flag. As a result,
// outputs change one edge after the state transition that causes them.

module debug_unlock_ctrl #(
   parameter logic [15:0] UNLOCK_KEY     = 16'hA5C3,
   parameter int unsigned MAX_FAIL       = 3,
   parameter int unsigned CHECK_DELAY    = 8,
   parameter int unsigned SESSION_CYCLES = 1024
) (
   input  logic                            Clk,
   input  logic                            resetn,
   input  logic                            boot_done,
   input  logic                            dbg_req,
   input  logic [15:0]                     dbg_key,
   input  logic                            dbg_exit,
   output logic                            Lock,
   output logic                            trusted,
   output logic                            debug_mode,
   output logic                            dbg_ack,
   output logic                            dbg_nack,
   output logic                            lockout,
   output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count
);

   localparam int unsigned FailW = $clog2(MAX_FAIL + 1);
   localparam int unsigned DlyW  = $clog2(CHECK_DELAY + 1);
   localparam int unsigned SessW = $clog2(SESSION_CYCLES + 1);

   localparam logic [DlyW-1:0]  DlyLoad   = DlyW'(CHECK_DELAY - 1);
   localparam logic [SessW-1:0] SessLoad  = SessW'(SESSION_CYCLES - 1);
   localparam logic [FailW-1:0] FailMax   = FailW'(MAX_FAIL);
   localparam logic [FailW-1:0] FailLast  = FailW'(MAX_FAIL - 1);

   typedef enum logic [2:0] {
      StIdle,
      StLocked,
      StCheck,
      StDebug,
      StLockout
   } state_e;

   state_e           r_state;
   state_e           w_state_d;
   logic [15:0]      r_key;
   logic [15:0]      w_key_d;
   logic [DlyW-1:0]  r_dly;
   logic [DlyW-1:0]  w_dly_d;
   logic [SessW-1:0] r_sess;
   logic [SessW-1:0] w_sess_d;
   logic [FailW-1:0] r_fail;
   logic [FailW-1:0] w_fail_d;
   // Verdict pulses are staged here so ack/nack line up with the state-derived outputs.
   logic             r_ack_pend;
   logic             w_ack_d;
   logic             r_nack_pend;
   logic             w_nack_d;

   always_comb begin
      w_state_d = r_state;
      w_key_d   = r_key;
      w_dly_d   = r_dly;
      w_sess_d  = r_sess;
      w_fail_d  = r_fail;
      w_ack_d   = 1'b0;
      w_nack_d  = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (boot_done) begin
               w_state_d = StLocked;
            end
         end

         StLocked: begin
            if (dbg_req) begin
               w_key_d   = dbg_key;
               w_dly_d   = DlyLoad;
               w_state_d = StCheck;
            end
         end

         StCheck: begin
            if (r_dly == '0) begin
               if (r_key == UNLOCK_KEY) begin
                  w_state_d = StDebug;
                  w_ack_d   = 1'b1;
                  w_fail_d  = '0;
                  w_sess_d  = SessLoad;
               end else begin
                  w_nack_d = 1'b1;
                  if (r_fail >= FailLast) begin
                     w_fail_d  = FailMax;
                     w_state_d = StLockout;
                  end else begin
                     w_fail_d  = r_fail + FailW'(1);
                     w_state_d = StLocked;
                  end
               end
            end else begin
               w_dly_d = r_dly - DlyW'(1);
            end
         end

         StDebug: begin
            if (dbg_exit || (r_sess == '0)) begin
               w_state_d = StLocked;
            end else begin
               w_sess_d = r_sess - SessW'(1);
            end
         end

         StLockout: begin
            w_state_d = StLockout;
         end

         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!resetn) begin
         r_state     <= StIdle;
         r_key       <= '0;
         r_dly       <= '0;
         r_sess      <= '0;
         r_fail      <= '0;
         r_ack_pend  <= 1'b0;
         r_nack_pend <= 1'b0;
         Lock        <= 1'b0;
         trusted     <= 1'b0;
         debug_mode  <= 1'b0;
         dbg_ack     <= 1'b0;
         dbg_nack    <= 1'b0;
         lockout     <= 1'b0;
         fail_count  <= '0;
      end else begin
         r_state     <= w_state_d;
         r_key       <= w_key_d;
         r_dly       <= w_dly_d;
         r_sess      <= w_sess_d;
         r_fail      <= w_fail_d;
         r_ack_pend  <= w_ack_d;
         r_nack_pend <= w_nack_d;
         Lock        <= (r_state != StIdle);
         trusted     <= (r_state == StDebug);
         debug_mode  <= (r_state == StDebug);
         dbg_ack     <= r_ack_pend;
         dbg_nack    <= r_nack_pend;
         lockout     <= (r_state == StLockout);
         fail_count  <= r_fail;
      end
   end

endmodule

// File: tb/tb_debug_unlock_ctrl.sv
// Testbench for debug_unlock_ctrl: directed scenarios followed by randomized traffic. All
// outputs are compared every cycle against a deadline-based reference model.

module tb_debug_unlock_ctrl;

   localparam logic [15:0] Key    = 16'hA5C3;
   localparam int          MaxF   = 3;
   localparam int          Cd     = 8;
   localparam int          Sess   = 1024;

   logic        Clk;
   logic        resetn;
   logic        boot_done;
   logic        dbg_req;
   logic [15:0] dbg_key;
   logic        dbg_exit;
   logic        Lock;
   logic        trusted;
   logic        debug_mode;
   logic        dbg_ack;
   logic        dbg_nack;
   logic        lockout;
   logic [1:0]  fail_count;

   debug_unlock_ctrl #(
      .UNLOCK_KEY     (Key),
      .MAX_FAIL       (MaxF),
      .CHECK_DELAY    (Cd),
      .SESSION_CYCLES (Sess)
   ) u_dut (
      .Clk        (Clk),
      .resetn     (resetn),
      .boot_done  (boot_done),
      .dbg_req    (dbg_req),
      .dbg_key    (dbg_key),
      .dbg_exit   (dbg_exit),
      .Lock       (Lock),
      .trusted    (trusted),
      .debug_mode (debug_mode),
      .dbg_ack    (dbg_ack),
      .dbg_nack   (dbg_nack),
      .lockout    (lockout),
      .fail_count (fail_count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: absolute edge numbers mark when a check resolves and when a session ends.
   int          cyc       = 0;
   bit          m_booted  = 0;
   bit          m_chk     = 0;
   int          m_chk_at  = 0;
   logic [15:0] m_key     = '0;
   bit          m_dbg     = 0;
   int          m_dbg_end = 0;
   int          m_fails   = 0;
   bit          m_lo      = 0;
   bit          m_ack_p   = 0;
   bit          m_nack_p  = 0;

   bit e_lock, e_dbg, e_ack, e_nack, e_lo;
   int e_fc;

   int ack_cnt  = 0;
   int nack_cnt = 0;
   int dm_cnt   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_step();
      cyc++;
      // Outputs are registered: after this edge they reflect the model as it stood before it.
      e_lock = m_booted;
      e_dbg  = m_dbg;
      e_lo   = m_lo;
      e_fc   = m_fails;
      e_ack  = m_ack_p;
      e_nack = m_nack_p;
      if (!resetn) begin
         m_booted = 0; m_chk = 0; m_dbg = 0; m_fails = 0; m_lo = 0;
         m_ack_p = 0; m_nack_p = 0;
         e_lock = 0; e_dbg = 0; e_lo = 0; e_fc = 0; e_ack = 0; e_nack = 0;
         return;
      end
      m_ack_p  = 0;
      m_nack_p = 0;
      if (!m_booted) begin
         m_booted = boot_done;
      end else if (m_lo) begin
         // permanent until reset
      end else if (m_chk) begin
         if (cyc == m_chk_at) begin
            m_chk = 0;
            if (m_key == Key) begin
               m_dbg     = 1;
               m_dbg_end = cyc + Sess;
               m_fails   = 0;
               m_ack_p   = 1;
            end else begin
               m_fails  = m_fails + 1;
               m_nack_p = 1;
               if (m_fails >= MaxF) m_lo = 1;
            end
         end
      end else if (m_dbg) begin
         if (dbg_exit || cyc == m_dbg_end) m_dbg = 0;
      end else if (dbg_req) begin
         m_chk    = 1;
         m_chk_at = cyc + Cd;
         m_key    = dbg_key;
      end
   endtask

   task automatic tick(input logic rn, input logic bd, input logic rq, input logic [15:0] k,
                       input logic ex);
      resetn    = rn;
      boot_done = bd;
      dbg_req   = rq;
      dbg_key   = k;
      dbg_exit  = ex;
      @(posedge Clk);
      model_step();
      @(negedge Clk);
      check_val("lock",       32'(Lock),       32'(e_lock));
      check_val("trusted",    32'(trusted),    32'(e_dbg));
      check_val("debug_mode", 32'(debug_mode), 32'(e_dbg));
      check_val("ack",        32'(dbg_ack),    32'(e_ack));
      check_val("nack",       32'(dbg_nack),   32'(e_nack));
      check_val("lockout",    32'(lockout),    32'(e_lo));
      check_val("fail_count", 32'(fail_count), 32'(e_fc));
      if (dbg_ack)    ack_cnt++;
      if (dbg_nack)   nack_cnt++;
      if (debug_mode) dm_cnt++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 16'($urandom), 1'b0);
   endtask

   task automatic boot_up();
      tick(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      idle(2);
   endtask

   task automatic wrong_key();
      tick(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
      idle(Cd + 2);
   endtask

   initial begin
      resetn = 1'b0; boot_done = 1'b0; dbg_req = 1'b0; dbg_key = '0; dbg_exit = 1'b0;

      // Reset, idle with ignored request, then boot pulse.
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      idle(2);
      ack_cnt = 0; nack_cnt = 0;
      tick(1'b1, 1'b0, 1'b1, Key, 1'b0);
      idle(Cd + 3);
      check_val("idle_req_ack", 32'(ack_cnt + nack_cnt), 32'd0);
      check_val("idle_lock", 32'(Lock), 32'd0);
      boot_up();
      check_val("boot_lock", 32'(Lock), 32'd1);

      // Full-length session; key and request wiggled during CHECK.
      ack_cnt = 0; dm_cnt = 0;
      tick(1'b1, 1'b0, 1'b1, Key, 1'b0);
      for (int i = 0; i < Cd; i++) tick(1'b1, 1'b0, 1'(i % 2), 16'($urandom), 1'b0);
      idle(Sess + 20);
      check_val("session_len", 32'(dm_cnt), 32'(Sess));
      check_val("session_ack", 32'(ack_cnt), 32'd1);

      // Exit on the 5th session cycle, then a fresh correct request.
      dm_cnt = 0;
      tick(1'b1, 1'b0, 1'b1, Key, 1'b0);
      idle(Cd + 4);
      tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
      idle(3);
      check_val("exit_len", 32'(dm_cnt), 32'd5);
      ack_cnt = 0;
      tick(1'b1, 1'b0, 1'b1, Key, 1'b0);
      idle(Cd + 10);
      tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
      idle(3);
      check_val("reaccept_ack", 32'(ack_cnt), 32'd1);

      // Three wrong keys -> lockout; a correct key afterwards gets no reply.
      nack_cnt = 0;
      for (int i = 0; i < 3; i++) wrong_key();
      check_val("lo_nacks", 32'(nack_cnt), 32'd3);
      check_val("lo_flag", 32'(lockout), 32'd1);
      check_val("lo_count", 32'(fail_count), 32'd3);
      ack_cnt = 0; nack_cnt = 0;
      tick(1'b1, 1'b1, 1'b1, Key, 1'b0);
      idle(Cd + 5);
      check_val("lo_silent", 32'(ack_cnt + nack_cnt), 32'd0);

      // Reset in LOCKOUT, two wrong, one correct, two wrong: no lockout.
      tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      idle(2);
      boot_up();
      wrong_key();
      wrong_key();
      check_val("fc_two", 32'(fail_count), 32'd2);
      tick(1'b1, 1'b0, 1'b1, Key, 1'b0);
      idle(Cd + 4);
      check_val("fc_clear", 32'(fail_count), 32'd0);
      tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
      idle(2);
      wrong_key();
      wrong_key();
      check_val("no_lockout", 32'(lockout), 32'd0);

      // Reset in the middle of CHECK discards the pending verdict.
      ack_cnt = 0; nack_cnt = 0;
      tick(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
      idle(3);
      tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      idle(Cd + 4);
      check_val("midchk_silent", 32'(ack_cnt + nack_cnt), 32'd0);
      boot_up();

      // Randomized traffic.
      for (int i = 0; i < 8000; i++) begin
         tick(1'($urandom_range(0, 599) != 0),
              1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 7) == 0),
              ($urandom_range(0, 1) == 0) ? Key : 16'($urandom),
              1'($urandom_range(0, 299) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
